// File: rtl/adaptive_filter.sv
// adaptive_filter: two-stage switchable differentiator / trapezoidal integrator on a valid-only stream
module adaptive_filter #(
    parameter int WORDLENGTH        = 14,
    parameter int FRACTIONAL_LENGTH = 6
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic                         ctrl,
    input  logic signed [WORDLENGTH-1:0] s_tdata,
    input  logic                         s_tvalid,
    output logic signed [WORDLENGTH-1:0] m_tdata,
    output logic                         m_tvalid
);
    localparam int W = WORDLENGTH;
    localparam logic signed [W+1:0] P_MAX = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] P_MIN = {3'b111, {(W-1){1'b0}}};

    if (FRACTIONAL_LENGTH < 0 || FRACTIONAL_LENGTH >= WORDLENGTH) begin : g_fl_range
        $error("FRACTIONAL_LENGTH out of range");
    end

    logic signed [W-1:0] r_x, r_xprev, r_acc;
    logic                r_c, r_v1, r_mode;
    logic                w_clr;
    logic signed [W-1:0] w_xp, w_ap, w_y;
    logic signed [W:0]   w_d, w_s, w_h;
    logic signed [W+1:0] w_a;

    function automatic logic signed [W-1:0] sat(input logic signed [W+1:0] v);
        return v > P_MAX ? P_MAX[W-1:0] : v < P_MIN ? P_MIN[W-1:0] : v[W-1:0];
    endfunction

    // a mode change restarts the filter from zero history
    always_comb begin
        w_clr = r_c != r_mode;
        w_xp  = w_clr ? '0 : r_xprev;
        w_ap  = w_clr ? '0 : r_acc;
        w_d   = r_x - w_xp;
        w_s   = r_x + w_xp;
        w_h   = (w_s + signed'((W+1)'(1))) >>> 1;
        w_a   = w_ap + w_h;
        w_y   = r_c ? sat(w_a) : sat({w_d[W], w_d});
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_x      <= '0;
            r_c      <= 1'b0;
            r_v1     <= 1'b0;
            r_xprev  <= '0;
            r_acc    <= '0;
            r_mode   <= 1'b0;
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
        end else begin
            r_v1     <= s_tvalid;
            m_tvalid <= r_v1;
            if (s_tvalid) begin
                r_x <= s_tdata;
                r_c <= ctrl;
            end
            if (r_v1) begin
                r_xprev <= r_x;
                r_mode  <= r_c;
                m_tdata <= w_y;
                if (r_c)
                    r_acc <= w_y;
            end
        end
    end
endmodule

// File: tb/tb_adaptive_filter.sv
// tb_adaptive_filter: directed vectors with a queue scoreboard and a decoupled output monitor
module tb_adaptive_filter;
    logic               clk = 1'b0;
    logic               srst = 1'b1;
    logic               ctrl = 1'b0;
    logic signed [13:0] s_tdata = '0;
    logic               s_tvalid = 1'b0;
    logic signed [13:0] m_tdata;
    logic               m_tvalid;

    logic signed [13:0] q[$];
    int                 n_pass = 0;
    int                 n_total = 0;

    adaptive_filter #(.WORDLENGTH(14), .FRACTIONAL_LENGTH(6)) dut (
        .clk(clk), .srst(srst), .ctrl(ctrl), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic send(input logic c, input logic signed [13:0] x, input logic signed [13:0] e);
        @(negedge clk);
        srst = 1'b0;
        ctrl = c;
        s_tdata = x;
        s_tvalid = 1'b1;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_tvalid = 1'b0;
        end
    endtask

    task automatic do_reset();
        idle(3);
        @(negedge clk);
        srst = 1'b1;
        s_tvalid = 1'b0;
        @(negedge clk);
        srst = 1'b0;
    endtask

    // monitor: every output beat must match the oldest outstanding expectation
    always @(posedge clk) begin
        #1;
        if (m_tvalid) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_out: got %0d expected no output", m_tdata);
            end else begin
                chk("out_data", int'(m_tdata), int'(q.pop_front()));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) begin
            @(negedge clk);
            chk("rst_tvalid", int'(m_tvalid), 0);
            chk("rst_tdata", int'(m_tdata), 0);
        end
        @(negedge clk);
        srst = 1'b0;

        send(1'b0, 14'sd64, 14'sd64);
        @(negedge clk);
        s_tvalid = 1'b0;
        chk("lat_k1", int'(m_tvalid), 0);
        @(negedge clk);
        chk("lat_k2", int'(m_tvalid), 1);
        @(negedge clk);
        chk("lat_k3", int'(m_tvalid), 0);

        do_reset();
        send(1'b0, 14'sd64, 14'sd64);
        send(1'b0, 14'sd192, 14'sd128);
        send(1'b0, 14'sd128, -14'sd64);

        do_reset();
        send(1'b1, 14'sd64, 14'sd32);
        send(1'b1, 14'sd64, 14'sd96);
        send(1'b1, 14'sd64, 14'sd160);
        send(1'b1, 14'sd0, 14'sd192);

        do_reset();
        send(1'b1, 14'sd8191, 14'sd4096);
        send(1'b1, 14'sd8191, 14'sd8191);

        do_reset();
        send(1'b0, 14'sd8191, 14'sd8191);
        send(1'b0, -14'sd8192, -14'sd8192);

        do_reset();
        send(1'b1, 14'sd64, 14'sd32);
        send(1'b1, 14'sd64, 14'sd96);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            if (i == 2) chk("hold_tvalid", int'(m_tvalid), 0);
        end
        chk("hold_tdata", int'(m_tdata), 96);
        send(1'b0, 14'sd128, 14'sd128);

        do_reset();
        for (int i = 0; i < 128; i++) begin
            if (i == 64) begin
                @(negedge clk);
                srst = 1'b1;
                ctrl = 1'b0;
                s_tdata = 14'(3 * i);
                s_tvalid = 1'b1;
                q.delete();
            end else begin
                send(1'b0, 14'(3 * i), (i == 0) ? 14'sd0 : (i == 65) ? 14'sd195 : 14'sd3);
            end
        end

        idle(6);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
